// File: rtl/token_lexer.sv
// Streaming lexer: splits an ASCII byte stream at delimiters and classifies each token.
// Build option: define TOKEN_LEXER_UNDERSCORE_EN to treat '_' (0x5F) as a letter.
module token_lexer #(
  parameter  int MAX_LEN = 16,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  input  logic [7:0]       char_i,
  output logic             tok_valid_o,
  output logic [1:0]       tok_kind_o,
  output logic [LEN_W-1:0] tok_len_o,
  output logic             in_ident_o,
  output logic [CNT_W-1:0] tok_count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IDENT,
    S_NUM,
    S_BAD
  } state_e;

  localparam logic [1:0]       K_NONE  = 2'b00;
  localparam logic [1:0]       K_IDENT = 2'b01;
  localparam logic [1:0]       K_NUM   = 2'b10;
  localparam logic [1:0]       K_BAD   = 2'b11;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             tok_valid_q;
  logic [1:0]       tok_kind_q;
  logic [LEN_W-1:0] tok_len_q;
  logic             in_ident_q;
  logic [CNT_W-1:0] tok_count_q, tok_count_d;
  logic             emit_d;
  logic [1:0]       emit_kind_d;

  logic             is_letter;
  logic             is_digit;
  logic             is_word;
  logic             len_at_max;
  logic [LEN_W-1:0] len_inc;

  always_comb begin
    is_letter = ((char_i >= 8'h41) && (char_i <= 8'h5A)) ||
                ((char_i >= 8'h61) && (char_i <= 8'h7A));
`ifdef TOKEN_LEXER_UNDERSCORE_EN
    is_letter = is_letter || (char_i == 8'h5F);
`else
    is_letter = is_letter && (char_i != 8'h5F);
`endif
    is_digit   = (char_i >= 8'h30) && (char_i <= 8'h39);
    is_word    = is_letter || is_digit;
    len_at_max = (len_q == LEN_MAX);
    len_inc    = len_at_max ? len_q : len_q + LEN_ONE;
  end

  // Next-state and emission decision for the accepted character.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    emit_d      = 1'b0;
    emit_kind_d = K_NONE;
    if (in_valid_i) begin
      case (state_q)
        S_IDLE: begin
          if (is_letter) begin
            state_d = S_IDENT;
            len_d   = LEN_ONE;
          end else if (is_digit) begin
            state_d = S_NUM;
            len_d   = LEN_ONE;
          end
        end
        S_IDENT: begin
          if (is_word) begin
            state_d = len_at_max ? S_BAD : S_IDENT;
            len_d   = len_inc;
          end else begin
            state_d     = S_IDLE;
            len_d       = '0;
            emit_d      = 1'b1;
            emit_kind_d = K_IDENT;
          end
        end
        S_NUM: begin
          if (is_digit) begin
            state_d = len_at_max ? S_BAD : S_NUM;
            len_d   = len_inc;
          end else if (is_letter) begin
            state_d = S_BAD;
            len_d   = len_inc;
          end else begin
            state_d     = S_IDLE;
            len_d       = '0;
            emit_d      = 1'b1;
            emit_kind_d = K_NUM;
          end
        end
        S_BAD: begin
          if (is_word) begin
            len_d = len_inc;
          end else begin
            state_d     = S_IDLE;
            len_d       = '0;
            emit_d      = 1'b1;
            emit_kind_d = K_BAD;
          end
        end
        default: begin
          state_d = S_IDLE;
          len_d   = '0;
        end
      endcase
    end
  end

  // Malformed tokens are reported but never counted; the counter sticks at all-ones.
  always_comb begin
    tok_count_d = tok_count_q;
    if (emit_d && (emit_kind_d != K_BAD) && (tok_count_q != CNT_MAX)) begin
      tok_count_d = tok_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      tok_valid_q <= 1'b0;
      tok_kind_q  <= K_NONE;
      tok_len_q   <= '0;
      in_ident_q  <= 1'b0;
      tok_count_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      tok_valid_q <= emit_d;
      if (emit_d) begin
        tok_kind_q <= emit_kind_d;
        tok_len_q  <= len_q;
      end
      in_ident_q  <= (state_d == S_IDENT);
      tok_count_q <= tok_count_d;
    end
  end

  assign tok_valid_o = tok_valid_q;
  assign tok_kind_o  = tok_kind_q;
  assign tok_len_o   = tok_len_q;
  assign in_ident_o  = in_ident_q;
  assign tok_count_o = tok_count_q;

endmodule

// File: tb/tb_token_lexer.sv
// Self-checking bench for token_lexer: a default instance (16/8) and a small one (4/2)
// share one stimulus stream; directed table, hand sequences and a random run vs a token-level model.
module tb_token_lexer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] ch;

  logic       tv0, ii0;
  logic [1:0] tk0;
  logic [4:0] tl0;
  logic [7:0] tc0;

  logic       tv1, ii1;
  logic [1:0] tk1;
  logic [2:0] tl1;
  logic [1:0] tc1;

  token_lexer dut0 (
    .clk_i(clk), .reset_i(rst), .in_valid_i(in_valid), .char_i(ch),
    .tok_valid_o(tv0), .tok_kind_o(tk0), .tok_len_o(tl0),
    .in_ident_o(ii0), .tok_count_o(tc0)
  );

  token_lexer #(.MAX_LEN(4), .CNT_W(2)) dut1 (
    .clk_i(clk), .reset_i(rst), .in_valid_i(in_valid), .char_i(ch),
    .tok_valid_o(tv1), .tok_kind_o(tk1), .tok_len_o(tl1),
    .in_ident_o(ii1), .tok_count_o(tc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pulses0 = 0;

  // Token-level reference: the partial token is kept as a list of characters.
  logic [7:0] tok_q[$];
  int  maxl[2] = '{16, 4};
  int  cmax[2] = '{255, 3};
  bit  exp_valid;
  int  exp_kind[2];
  int  exp_len[2];
  int  exp_cnt[2];
  bit  exp_ident[2];

  function automatic bit is_letter(logic [7:0] c);
    bit r;
    r = (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
`ifdef TOKEN_LEXER_UNDERSCORE_EN
    if (c == 8'h5F) r = 1'b1;
`endif
    return r;
  endfunction

  function automatic bit is_digit(logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39);
  endfunction

  function automatic int classify(int ml);
    bit all_dig;
    if (tok_q.size() > ml) return 3;
    all_dig = 1'b1;
    foreach (tok_q[i]) if (!is_digit(tok_q[i])) all_dig = 1'b0;
    if (all_dig) return 2;
    if (is_letter(tok_q[0])) return 1;
    return 3;
  endfunction

  function automatic void model_step(bit r, bit v, logic [7:0] c);
    if (r) begin
      tok_q.delete();
      exp_valid = 1'b0;
      for (int k = 0; k < 2; k++) exp_cnt[k] = 0;
    end else if (!v) begin
      exp_valid = 1'b0;
    end else if (is_letter(c) || is_digit(c)) begin
      tok_q.push_back(c);
      exp_valid = 1'b0;
    end else if (tok_q.size() == 0) begin
      exp_valid = 1'b0;
    end else begin
      exp_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
        exp_kind[k] = classify(maxl[k]);
        exp_len[k]  = (tok_q.size() > maxl[k]) ? maxl[k] : tok_q.size();
        if (exp_kind[k] != 3 && exp_cnt[k] < cmax[k]) exp_cnt[k]++;
      end
      tok_q.delete();
    end
    for (int k = 0; k < 2; k++)
      exp_ident[k] = (tok_q.size() > 0) && is_letter(tok_q[0]) && (tok_q.size() <= maxl[k]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m0_valid", int'(tv0), int'(exp_valid));
    chk("m1_valid", int'(tv1), int'(exp_valid));
    if (exp_valid) begin
      chk("m0_kind", int'(tk0), exp_kind[0]);
      chk("m0_len",  int'(tl0), exp_len[0]);
      chk("m1_kind", int'(tk1), exp_kind[1]);
      chk("m1_len",  int'(tl1), exp_len[1]);
    end
    chk("m0_count", int'(tc0), exp_cnt[0]);
    chk("m1_count", int'(tc1), exp_cnt[1]);
    chk("m0_ident", int'(ii0), int'(exp_ident[0]));
    chk("m1_ident", int'(ii1), int'(exp_ident[1]));
  endtask

  task automatic cycle(input bit r, input bit v, input logic [7:0] c);
    rst      = r;
    in_valid = v;
    ch       = c;
    @(posedge clk);
    #1;
    model_step(r, v, c);
    if (tv0) pulses0++;
    check_model();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) cycle(1'b0, 1'b1, s[i]);
  endtask

  // Directed vectors for the default instance, expected values written out by hand.
  typedef struct {
    bit         r;
    bit         v;
    logic [7:0] c;
    bit         e_valid;
    int         e_kind;
    int         e_len;
    int         e_cnt;
    bit         e_ident;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, bit v, logic [7:0] c, bit ev, int ek, int el, int ec, bit ei);
    vec_t t;
    t.r = r; t.v = v; t.c = c;
    t.e_valid = ev; t.e_kind = ek; t.e_len = el; t.e_cnt = ec; t.e_ident = ei;
    vecs.push_back(t);
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; ch = 8'h00;

    // reset, then "ab12 " plus one idle cycle
    add(1, 0, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, "a",   0, 0, 0, 0, 1);
    add(0, 1, "b",   0, 0, 0, 0, 1);
    add(0, 1, "1",   0, 0, 0, 0, 1);
    add(0, 1, "2",   0, 0, 0, 0, 1);
    add(0, 1, " ",   1, 1, 4, 1, 0);
    add(0, 0, 8'h00, 0, 0, 0, 1, 0);
    // "123;x  " with a trailing extra delimiter
    add(1, 0, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, "1",   0, 0, 0, 0, 0);
    add(0, 1, "2",   0, 0, 0, 0, 0);
    add(0, 1, "3",   0, 0, 0, 0, 0);
    add(0, 1, ";",   1, 2, 3, 1, 0);
    add(0, 1, "x",   0, 0, 0, 1, 1);
    add(0, 1, " ",   1, 1, 1, 2, 0);
    add(0, 1, " ",   0, 0, 0, 2, 0);
    // "12a " malformed, not counted
    add(1, 0, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, "1",   0, 0, 0, 0, 0);
    add(0, 1, "2",   0, 0, 0, 0, 0);
    add(0, 1, "a",   0, 0, 0, 0, 0);
    add(0, 1, " ",   1, 3, 3, 0, 0);
    // "ab " with three idle cycles between characters
    add(1, 0, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, "a",   0, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 0, 0, 1);
    add(0, 0, "b",   0, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 0, 0, 1);
    add(0, 1, "b",   0, 0, 0, 0, 1);
    add(0, 0, " ",   0, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 0, 0, 1);
    add(0, 1, " ",   1, 1, 2, 1, 0);
    // reset in the middle of "ab": token discarded, nothing emitted afterwards
    add(0, 1, "a",   0, 0, 0, 1, 1);
    add(0, 1, "b",   0, 0, 0, 1, 1);
    add(1, 1, "c",   0, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, " ",   0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].r, vecs[i].v, vecs[i].c);
      chk($sformatf("tbl%0d_valid", i), int'(tv0), int'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("tbl%0d_kind", i), int'(tk0), vecs[i].e_kind);
        chk($sformatf("tbl%0d_len", i),  int'(tl0), vecs[i].e_len);
      end
      chk($sformatf("tbl%0d_count", i), int'(tc0), vecs[i].e_cnt);
      chk($sformatf("tbl%0d_ident", i), int'(ii0), int'(vecs[i].e_ident));
    end

    // Small instance: over-length identifier, then exactly MAX_LEN
    cycle(1'b1, 1'b0, 8'h00);
    send_str("abcde ");
    chk("max_over_valid", int'(tv1), 1);
    chk("max_over_kind",  int'(tk1), 3);
    chk("max_over_len",   int'(tl1), 4);
    send_str("abcd ");
    chk("max_exact_valid", int'(tv1), 1);
    chk("max_exact_kind",  int'(tk1), 1);
    chk("max_exact_len",   int'(tl1), 4);
    chk("max_exact_count", int'(tc1), 1);

    // Counter saturation on the 2-bit instance
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) send_str("a ");
    chk("sat_count1", int'(tc1), 3);
    chk("sat_count0", int'(tc0), 6);
    cycle(1'b0, 1'b0, 8'h00);
    chk("sat_hold1", int'(tc1), 3);

    // Underscore handling
    pulses0 = 0;
    send_str("a_b ");
    chk("us_kind", int'(tk0), 1);
`ifdef TOKEN_LEXER_UNDERSCORE_EN
    chk("us_pulses", pulses0, 1);
    chk("us_len", int'(tl0), 3);
`else
    chk("us_pulses", pulses0, 2);
    chk("us_len", int'(tl0), 1);
`endif

    // Random run against the reference model
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4000; i++) begin
      int         sel;
      bit         long_mode;
      logic [7:0] c;
      long_mode = ((i / 400) % 2) == 1;
      sel = long_mode ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 15));
      if (sel <= 5 || (long_mode && sel >= 16 && sel <= 22))
        c = ($urandom_range(0, 1) != 0) ? 8'(8'h41 + $urandom_range(0, 25))
                                        : 8'(8'h61 + $urandom_range(0, 25));
      else if (sel <= 10 || (long_mode && sel <= 29))
        c = 8'(8'h30 + $urandom_range(0, 9));
      else if (sel == 11)
        c = 8'h5F;
      else if (sel == 12 || sel == 30)
        c = 8'h20;
      else if (sel == 13)
        c = 8'h3B;
      else
        c = 8'($urandom_range(0, 255));
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) != 0), c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/token_lexer.md
Name: token_lexer

Overview:
- Parametrised streaming lexer for the character-FSM family.
- Consumes one 8-bit ASCII character per accepted cycle and splits the stream into tokens at delimiters.
- Classifies each token as identifier (letter, then letters/digits), decimal number (digits only) or malformed.
- Reports each token's kind and length on a one-cycle pulse and keeps a saturating count of good tokens.

Parameters:
- MAX_LEN, 16: maximum legal token length in characters; must be >= 1.
- CNT_W, 8: width of the good-token counter.
- Derived localparam LEN_W = $clog2(MAX_LEN+1): width of the length field.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  char is presented and consumed this cycle.
- char  in  8  ASCII character.
- tok_valid  out  1  one-cycle pulse: a token ended on the previous accepted delimiter.
- tok_kind  out  2  00 none, 01 identifier, 10 number, 11 malformed; valid with tok_valid.
- tok_len  out  LEN_W  length of the ended token, saturating at MAX_LEN; valid with tok_valid.
- in_ident  out  1  level: current partial token is a well-formed identifier (state IDENT).
- tok_count  out  CNT_W  number of identifier+number tokens emitted, saturating at all-ones.

Behaviour:
- Character classes:
  - LETTER: 0x41-0x5A or 0x61-0x7A.
  - DIGIT: 0x30-0x39.
  - DELIM: anything else.
- States are IDLE, IDENT, NUM and BAD. All outputs are registered. Reset: state IDLE, len 0, tok_valid 0, tok_kind 00, tok_len 0, in_ident 0, tok_count 0.
- in_valid=0: state, len and tok_count hold; tok_valid drives 0 in that cycle.
- Transitions on an accepted char, with len = characters accepted into the current token:
  - IDLE: LETTER -> IDENT, len=1. DIGIT -> NUM, len=1. DELIM -> IDLE, no token emitted.
  - IDENT: LETTER/DIGIT with len<MAX_LEN -> IDENT, len+1. LETTER/DIGIT with len==MAX_LEN -> BAD, len stays MAX_LEN. DELIM -> IDLE, emit kind 01.
  - NUM: DIGIT with len<MAX_LEN -> NUM, len+1. DIGIT with len==MAX_LEN -> BAD. LETTER -> BAD, len+1 saturating. DELIM -> IDLE, emit kind 10.
  - BAD: LETTER/DIGIT -> BAD, len+1 saturating at MAX_LEN. DELIM -> IDLE, emit kind 11.
- Emission:
  - Occurs in the cycle after the delimiter is accepted (latency 1).
  - tok_valid=1 for exactly one cycle; tok_len = len before the delimiter; len resets to 0.
  - Back-to-back delimiters emit nothing after the first.
- tok_count increments by 1 on each emission with kind 01 or 10. It saturates and never wraps. Kind 11 does not count.
- in_ident is registered and equals (next state == IDENT), so it reflects the prefix including the last accepted char.
- tok_kind and tok_len hold their last values when tok_valid=0; the bench checks them only when tok_valid=1.
- Mid-token reset: the token is discarded, nothing is emitted, and all state returns to reset values the next cycle. Reset has priority over in_valid.
- No end-of-stream flush: an unterminated token is never reported.

Optional Feature:
- Macro: TOKEN_LEXER_UNDERSCORE_EN.
- Defined:
  - '_' (0x5F) is classed as LETTER, so "_a1" and "a_b" are identifiers.
  - In NUM, '_' transitions to BAD like any letter.
- Undefined: '_' is DELIM, so "a_b" yields two identifiers of length 1.

Test Plan:
- Reset, then "ab12 " with in_valid=1 continuously -> in_ident=1 after 'a'. Cycle after the space: tok_valid=1, tok_kind=01, tok_len=4, tok_count=1. in_ident=0.
- "123;x " -> first pulse kind=10 len=3, then kind=01 len=1. tok_count=2. Nothing emitted for the extra delimiter.
- "12a " -> BAD entered at 'a'. Pulse kind=11 len=3. tok_count stays 0.
- MAX_LEN=4, "abcde " -> BAD at 'e'. Pulse kind=11 len=4. Then "abcd " -> kind=01 len=4.
- "ab" with in_valid gaps of 3 idle cycles between chars, then ' ' -> pulse kind=01 len=2. tok_valid=0 in every gap cycle. Separately, reset asserted after "ab" with no delimiter -> no pulse, tok_count=0, in_ident=0.
- CNT_W=2, six tokens "a " -> tok_count reaches 3 and stays 3. Then "a_b ": with TOKEN_LEXER_UNDERSCORE_EN, one pulse kind=01 len=3; without it, two pulses kind=01 len=1.
